// File: rtl/opc5_uart.sv
// OPC5 memory-mapped 8N1 UART with 8-entry TX/RX FIFOs and a programmable bit divisor.
// Define OPC5_UART_IRQ_EN to add the IRQEN register and the irq output.
module opc5_uart_fifo #(
    parameter int unsigned AW = 3
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_full
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module opc5_uart #(
    parameter logic [15:0] CLK_DIV = 16'd434,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        cs,
    input  logic [1:0]  addr,
    input  logic        rnw,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        rxd,
    output logic        txd
`ifdef OPC5_UART_IRQ_EN
    ,
    output logic        irq
`endif
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [15:0] r_div;
    logic        r_overrun;
    logic        r_ferr;
    logic [15:0] w_div_eff;
    logic        w_tx_push, w_rx_pop, w_stat_wr;
    logic [7:0]  w_tx_head, w_rx_head;
    logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic        w_tx_idle;
    logic [15:0] w_status;

    tx_state_t   r_tx_state, w_tx_state_n;
    logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_shift, w_tx_shift_n;
    logic        r_txd, w_txd_n, w_tx_pop, w_tx_load;

    rx_state_t   r_rx_state, w_rx_state_n;
    logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_shift, w_rx_shift_n;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    logic        w_rx_push, w_set_ferr, w_set_ovr;

    assign w_div_eff = (r_div < 16'd2) ? 16'd2 : r_div;
    assign w_tx_push = cs & ~rnw & (addr == 2'd0);
    assign w_rx_pop  = cs &  rnw & (addr == 2'd0);
    assign w_stat_wr = cs & ~rnw & (addr == 2'd1);
    assign w_tx_idle = (r_tx_state == TX_IDLE) & w_tx_empty;
    assign w_set_ovr = w_rx_push & w_rx_full & ~w_rx_pop;
    assign w_status  = {11'b0, r_ferr, w_tx_idle, r_overrun, ~w_tx_full, ~w_rx_empty};
    assign txd       = r_txd;

    opc5_uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .reset_b(reset_b), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_data(din[7:0]), .o_data(w_tx_head), .o_empty(w_tx_empty), .o_full(w_tx_full)
    );
    opc5_uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .reset_b(reset_b), .i_push(w_rx_push), .i_pop(w_rx_pop),
        .i_data(r_rx_shift), .o_data(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
    );

`ifdef OPC5_UART_IRQ_EN
    logic [1:0] r_irqen;
    logic       r_irq;
    assign irq = r_irq;
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_irqen <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (cs && !rnw && addr == 2'd3) r_irqen <= din[1:0];
            r_irq <= (r_irqen[0] & ~w_rx_empty) | (r_irqen[1] & w_tx_idle);
        end
    end
`endif

    always_comb begin
        dout = '0;
        if (cs) begin
            case (addr)
                2'd0: dout = w_rx_empty ? 16'd0 : {8'd0, w_rx_head};
                2'd1: dout = w_status;
                2'd2: dout = r_div;
`ifdef OPC5_UART_IRQ_EN
                2'd3: dout = {14'd0, r_irqen};
`endif
                default: dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_div     <= CLK_DIV;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (cs && !rnw && addr == 2'd2) r_div <= din;
            r_overrun <= w_set_ovr  | (r_overrun & ~(w_stat_wr & din[2]));
            r_ferr    <= w_set_ferr | (r_ferr    & ~(w_stat_wr & din[4]));
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_div   <= w_tx_div_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_txd      <= w_txd_n;
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_div   <= w_rx_div_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt - 16'd1;
        w_tx_div_n   = r_tx_div;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_txd_n      = r_txd;
        w_tx_pop     = 1'b0;
        w_tx_load    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n = r_tx_cnt;
                w_tx_load  = ~w_tx_empty;
            end
            TX_START: if (r_tx_cnt == 16'd0) begin
                w_tx_state_n = TX_DATA;
                w_tx_cnt_n   = r_tx_div - 16'd1;
                w_tx_bit_n   = '0;
                w_txd_n      = r_tx_shift[0];
            end
            TX_DATA: if (r_tx_cnt == 16'd0) begin
                w_tx_cnt_n = r_tx_div - 16'd1;
                if (r_tx_bit == 3'd7) begin
                    w_tx_state_n = TX_STOP;
                    w_txd_n      = 1'b1;
                end else begin
                    w_tx_bit_n   = r_tx_bit + 3'd1;
                    w_tx_shift_n = r_tx_shift >> 1;
                    w_txd_n      = r_tx_shift[1];
                end
            end
            TX_STOP: if (r_tx_cnt == 16'd0) begin
                w_tx_state_n = TX_IDLE;
                w_tx_load    = ~w_tx_empty;
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
        // Frame start is shared by IDLE and the end of STOP so back-to-back frames have no gap.
        if (w_tx_load) begin
            w_tx_pop     = 1'b1;
            w_tx_state_n = TX_START;
            w_tx_shift_n = w_tx_head;
            w_tx_div_n   = w_div_eff;
            w_tx_cnt_n   = w_div_eff - 16'd1;
            w_txd_n      = 1'b0;
        end
    end

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt - 16'd1;
        w_rx_div_n   = r_rx_div;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_push    = 1'b0;
        w_set_ferr   = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_n = r_rx_cnt;
                // Edge detect means a line stuck low after a bad stop bit cannot re-arm.
                if (r_rx_s3 && !r_rx_s2) begin
                    w_rx_state_n = RX_START;
                    w_rx_div_n   = w_div_eff;
                    w_rx_cnt_n   = (w_div_eff >> 1) - 16'd1;
                end
            end
            RX_START: if (r_rx_cnt == 16'd0) begin
                w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
                w_rx_cnt_n   = r_rx_div - 16'd1;
                w_rx_bit_n   = '0;
            end
            RX_DATA: if (r_rx_cnt == 16'd0) begin
                w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                w_rx_cnt_n   = r_rx_div - 16'd1;
                w_rx_bit_n   = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
            end
            RX_STOP: if (r_rx_cnt == 16'd0) begin
                w_rx_state_n = RX_IDLE;
                w_rx_push    = r_rx_s2;
                w_set_ferr   = ~r_rx_s2;
            end
            default: w_rx_state_n = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_opc5_uart.sv
// Scoreboard bench for opc5_uart: bus reads and serial TX frames are checked by monitors.
`timescale 1ns/1ps
module tb_opc5_uart;
    logic        clk = 1'b0;
    logic        reset_b = 1'b1;
    logic        cs = 1'b0;
    logic        rnw = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [15:0] din = 16'd0;
    logic [15:0] dout;
    logic        txd;
    logic        rxd;
    logic        loop = 1'b0;
    logic        rx_drv = 1'b1;
`ifdef OPC5_UART_IRQ_EN
    logic        irq;
`endif

    assign rxd = loop ? txd : rx_drv;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] v;
        string       n;
    } rd_t;
    rd_t        rd_q[$];
    logic [7:0] tx_q[$];

    opc5_uart #(.CLK_DIV(16'd434), .FIFO_AW(3)) dut (
        .clk(clk), .reset_b(reset_b), .cs(cs), .addr(addr), .rnw(rnw),
        .din(din), .dout(dout), .rxd(rxd), .txd(txd)
`ifdef OPC5_UART_IRQ_EN
        , .irq(irq)
`endif
    );

    // Read monitor: every bus read cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        rd_t e;
        if (cs && rnw) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: addr=%0d dout=%h, no expectation queued", addr, dout);
            end else begin
                e = rd_q.pop_front();
                if (dout !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h", e.n, dout, e.v);
                end
            end
        end
    end

    // TX monitor: checks every cycle of a 40-cycle frame (divisor 4) against the queued byte.
    initial begin : txmon
        logic       prev;
        logic [9:0] fr;
        logic [7:0] exp_b;
        logic [7:0] got;
        bit         bad;
        bit         abort;
        bit         unexp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_b && prev && !txd) begin
                bad = 0; abort = 0; unexp = 0; got = '0;
                if (tx_q.size() == 0) begin
                    unexp = 1;
                    exp_b = '0;
                end else begin
                    exp_b = tx_q.pop_front();
                end
                fr = {1'b1, exp_b, 1'b0};
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (!reset_b) begin
                        abort = 1;
                        break;
                    end
                    if (txd !== fr[k/4]) bad = 1;
                    if (k >= 6 && k <= 34 && (k % 4) == 2) got[k/4-1] = txd;
                end
                if (!abort) begin
                    n_cmp++;
                    if (bad || unexp) begin
                        n_err++;
                        $display("FAIL tx_frame: got byte %h (timing_bad=%0d unexpected=%0d) want %h",
                                 got, bad, unexp, exp_b);
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cs = 1'b1; rnw = 1'b0; addr = a; din = d;
        @(posedge clk); #1;
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] e, input string n);
        rd_t t;
        t.v = e; t.n = n;
        rd_q.push_back(t);
        cs = 1'b1; rnw = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0; idle(4);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i]; idle(4);
        end
        rx_drv = stop; idle(4);
        rx_drv = 1'b1; idle(2);
    endtask

    task automatic chk(input logic act, input logic req, input string n);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b want %b", n, act, req);
        end
    endtask

    logic [7:0] pat [10];
    logic [7:0] b;

    initial begin
        pat = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h96, 8'h69, 8'h7E, 8'hE7};
        #2 reset_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(txd, 1'b1, "reset_txd");
        reset_b = 1'b1;
        idle(1);
        rd(2'd1, 16'h000A, "rst_status");
        rd(2'd2, 16'h01B2, "rst_div");
        rd(2'd3, 16'h0000, "rst_irqen");
        rd(2'd0, 16'h0000, "rst_data_empty");

        // Single frame, exact tx_idle timing
        wr(2'd2, 16'd4);
        rd(2'd2, 16'h0004, "div_rb");
        tx_q.push_back(8'h55);
        wr(2'd0, 16'h0055);
        @(posedge clk);
        repeat (39) @(posedge clk);
        #1;
        rd(2'd1, 16'h0002, "tx_busy_at_39");
        rd(2'd1, 16'h000A, "tx_idle_at_40");

        // Loopback
        loop = 1'b1;
        idle(2);
        tx_q.push_back(8'hA5);
        wr(2'd0, 16'h00A5);
        idle(60);
        rd(2'd1, 16'h000B, "loop_rx_avail");
        rd(2'd0, 16'h00A5, "loop_rx_data");
        rd(2'd1, 16'h000A, "loop_popped");
        loop = 1'b0;
        idle(2);

        // TX FIFO overflow with consecutive writes
        for (int i = 0; i < 10; i++) begin
            if (i < 9) tx_q.push_back(pat[i]);
            wr(2'd0, {8'h00, pat[i]});
        end
        rd(2'd1, 16'h0000, "tx_full");
        idle(9 * 40 + 20);
        rd(2'd1, 16'h000A, "tx_drained");

        // RX overrun
        for (int i = 0; i < 9; i++) rx_send(8'(17 * (i + 1)), 1'b1);
        idle(10);
        rd(2'd1, 16'h000F, "rx_overrun");
        for (int i = 0; i < 8; i++) begin
            b = 8'(17 * (i + 1));
            rd(2'd0, {8'h00, b}, "rx_fifo_order");
        end
        rd(2'd0, 16'h0000, "rx_empty_read");
        rd(2'd1, 16'h000E, "ovr_sticky");
        wr(2'd1, 16'h0004);
        rd(2'd1, 16'h000A, "ovr_clear");

        // Framing error, glitch rejection, re-arm
        rx_send(8'h3C, 1'b0);
        idle(4);
        rd(2'd1, 16'h001A, "frame_err");
        wr(2'd1, 16'h0010);
        rd(2'd1, 16'h000A, "ferr_clear");
        rx_drv = 1'b0; idle(1);
        rx_drv = 1'b1; idle(20);
        rd(2'd1, 16'h000A, "glitch_ignored");
        rx_send(8'h5A, 1'b1);
        idle(4);
        rd(2'd1, 16'h000B, "rearm_avail");
        rd(2'd0, 16'h005A, "rearm_data");

`ifdef OPC5_UART_IRQ_EN
        wr(2'd3, 16'h0001);
        rd(2'd3, 16'h0001, "irqen_rb");
        idle(2);
        chk(irq, 1'b0, "irq_quiet");
        rx_send(8'hC6, 1'b1);
        idle(4);
        chk(irq, 1'b1, "irq_rx");
        rd(2'd0, 16'h00C6, "irq_data");
        idle(2);
        chk(irq, 1'b0, "irq_cleared");
        wr(2'd3, 16'h0000);
`endif

        // Reset in the middle of a transmitted frame
        tx_q.push_back(8'hF0);
        wr(2'd0, 16'h00F0);
        idle(12);
        chk(txd, 1'b0, "midframe_busy");
        reset_b = 1'b0;
        #1;
        chk(txd, 1'b1, "midframe_reset_txd");
        idle(2);
        reset_b = 1'b1;
        idle(2);
        rd(2'd1, 16'h000A, "post_reset_status");
        rd(2'd2, 16'h01B2, "post_reset_div");
        idle(60);
        rd(2'd1, 16'h000A, "post_reset_quiet");

        idle(5);
        n_cmp++;
        if (tx_q.size() != 0) begin
            n_err++;
            $display("FAIL tx_leftover: got %0d untransmitted want 0", tx_q.size());
        end
        n_cmp++;
        if (rd_q.size() != 0) begin
            n_err++;
            $display("FAIL rd_leftover: got %0d unchecked want 0", rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
